// File: rtl/charlie_pwm_scan.sv
// Charlieplexed LED scanner with per-LED PWM intensity and a tear-free double-buffered frame.
// The host writes a staging copy at any time; the copy moves into the displayed shadow only at a frame boundary.
module charlie_pwm_scan #(
  parameter int PINS  = 8,
  parameter int BPP   = 2,
  parameter int DWELL = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [PINS*PINS*BPP-1:0]  fb_in,
  input  logic                      load,
  output logic [PINS-1:0]           pin_out,
  output logic [PINS-1:0]           pin_oe,
  output logic [$clog2(PINS)-1:0]   row_idx,
  output logic                      load_pending,
  output logic                      frame_done,
  output logic [7:0]                frame_count
);

  localparam int FBW       = PINS * PINS * BPP;
  localparam int PWM_STEPS = (1 << BPP) - 1;
  localparam int RW        = $clog2(PINS);
  localparam int SW        = (PWM_STEPS > 1) ? $clog2(PWM_STEPS) : 1;
  localparam int DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW        = (BPP > SW) ? BPP : SW;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [FBW-1:0]  stage_q, stage_d;
  logic [FBW-1:0]  shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic            frame_done_q, frame_done_d;
  logic [7:0]      frame_count_q, frame_count_d;
  logic            swap;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
    state_d       = state_q;
    row_d         = row_q;
    slot_d        = slot_q;
    dwell_d       = dwell_q;
    stage_d       = stage_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    swap          = 1'b0;

    if (!en) begin
      state_d = S_OFF;
      row_d   = '0;
      slot_d  = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BLANK;
          row_d   = '0;
          swap    = pending_q;
        end
        S_BLANK: begin
          state_d = S_DRIVE;
          slot_d  = '0;
          dwell_d = '0;
        end
        S_DRIVE: begin
          if (dwell_q == DW'(DWELL - 1)) begin
            dwell_d = '0;
            if (slot_q == SW'(PWM_STEPS - 1)) begin
              slot_d  = '0;
              state_d = S_BLANK;
              if (row_q == RW'(PINS - 1)) begin
                row_d         = '0;
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + 8'd1;
                swap          = pending_q;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              slot_d = slot_q + 1'b1;
            end
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    // Swap reads the old stage, so a load on the same edge stays staged for the next boundary.
    if (swap) begin
      shadow_d  = stage_q;
      pending_d = 1'b0;
    end
    if (load) begin
      stage_d   = fb_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q       <= S_OFF;
      row_q         <= '0;
      slot_q        <= '0;
      dwell_q       <= '0;
      // NOTE: the frame buffers are reset too; a blank display after reset is part of the contract.
      stage_q       <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      slot_q        <= slot_d;
      dwell_q       <= dwell_d;
      stage_q       <= stage_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Pin decode depends only on registered state and shadow.
  logic [PINS-1:0] lit;

  always_comb begin
    lit     = '0;
    pin_oe  = '0;
    pin_out = '0;
    for (int c = 0; c < PINS; c++) begin
      if (c != int'(row_q)) begin
        lit[c] = CW'(shadow_q[(int'(row_q) * PINS + c) * BPP +: BPP]) > CW'(slot_q);
      end
    end
    if (state_q == S_DRIVE && |lit) begin
      pin_oe         = lit;
      pin_oe[row_q]  = 1'b1;
      pin_out[row_q] = 1'b1;
    end
  end

  assign row_idx      = row_q;
  assign load_pending = pending_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_charlie_pwm_scan.sv
// Bench for charlie_pwm_scan: hand-computed vector table, corner sequences, and a random run
// compared every cycle against a frame-time model of the scanner.
module tb_charlie_pwm_scan;

  localparam int PINS      = 8;
  localparam int BPP       = 2;
  localparam int DWELL     = 4;
  localparam int FBW       = PINS * PINS * BPP;
  localparam int PWM_STEPS = (1 << BPP) - 1;
  localparam int ROW_P     = 1 + PWM_STEPS * DWELL;
  localparam int FRAME_P   = PINS * ROW_P;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [FBW-1:0]  fb_in = '0;
  logic            load = 1'b0;
  logic [PINS-1:0] pin_out, pin_oe;
  logic [2:0]      row_idx;
  logic            load_pending, frame_done;
  logic [7:0]      frame_count;

  charlie_pwm_scan #(.PINS(PINS), .BPP(BPP), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_in(fb_in), .load(load),
    .pin_out(pin_out), .pin_oe(pin_oe), .row_idx(row_idx),
    .load_pending(load_pending), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: time since the scan was enabled, plus the displayed/staged frames.
  bit             m_on;
  int             m_t;
  logic [FBW-1:0] m_stage, m_shadow;
  bit             m_pend, m_done;
  int             m_cnt;

  function automatic int level_of(input logic [FBW-1:0] fb, input int r, input int c);
    return int'(fb[(r * PINS + c) * BPP +: BPP]);
  endfunction

  function automatic logic [FBW-1:0] led(input int r, input int c, input int lvl);
    logic [FBW-1:0] v;
    v = '0;
    v[(r * PINS + c) * BPP +: BPP] = BPP'(lvl);
    return v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_on = 0; m_t = 0; m_stage = '0; m_shadow = '0; m_pend = 0; m_cnt = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!en) begin
        m_on = 0; m_t = 0;
      end else if (!m_on) begin
        m_on = 1; m_t = 0;
        if (m_pend) begin m_shadow = m_stage; m_pend = 0; end
      end else begin
        m_t = (m_t + 1) % FRAME_P;
        if (m_t == 0) begin
          m_done = 1;
          m_cnt  = (m_cnt + 1) % 256;
          if (m_pend) begin m_shadow = m_stage; m_pend = 0; end
        end
      end
      if (load) begin m_stage = fb_in; m_pend = 1; end
    end
  endtask

  task automatic model_outputs(output logic [7:0] oe, output logic [7:0] out, output int row);
    int pos, slot;
    logic [7:0] lits;
    oe = '0; out = '0; row = 0; lits = '0;
    if (m_on) begin
      row = m_t / ROW_P;
      pos = m_t % ROW_P;
      if (pos != 0) begin
        slot = (pos - 1) / DWELL;
        for (int c = 0; c < PINS; c++)
          if (c != row && level_of(m_shadow, row, c) > slot) lits[c] = 1'b1;
        if (lits != 0) begin
          oe  = lits | (8'd1 << row);
          out = 8'd1 << row;
        end
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] e_oe, e_out;
    int e_row;
    model_outputs(e_oe, e_out, e_row);
    check("m_oe", pin_oe, e_oe);
    check("m_out", pin_out, e_out);
    check("m_row", row_idx, e_row);
    check("m_pend", load_pending, m_pend);
    check("m_done", frame_done, m_done);
    check("m_cnt", frame_count, m_cnt);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Reset, stage fb while disabled, enable: the next cycle is BLANK row 0 showing fb.
  task automatic start_with(input logic [FBW-1:0] fb);
    rst_n = 0; en = 0; load = 0; tick();
    rst_n = 1; fb_in = fb; load = 1; tick();
    load = 0; en = 1; tick();
  endtask

  typedef struct {
    logic [FBW-1:0] fb;
    int             row;
    int             slot;
    logic [7:0]     exp_oe;
    logic [7:0]     exp_out;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    start_with(v.fb);
    repeat (v.row * ROW_P) tick();
    check("vec_blank_oe", pin_oe, 8'h00);
    repeat (1 + v.slot * DWELL) tick();
    for (int d = 0; d < DWELL; d++) begin
      check("vec_oe", pin_oe, v.exp_oe);
      check("vec_out", pin_out, v.exp_out);
      tick();
    end
  endtask

  logic [FBW-1:0] diag;
  logic [7:0]     oe_acc;

  initial begin
    diag = '0;
    for (int i = 0; i < PINS; i++) diag |= led(i, i, 3);

    vecs[0] = '{led(0, 1, 3), 0, 0, 8'h03, 8'h01};
    vecs[1] = '{led(0, 1, 3), 0, 2, 8'h03, 8'h01};
    vecs[2] = '{led(2, 5, 1) | led(2, 6, 2), 2, 0, 8'h64, 8'h04};
    vecs[3] = '{led(2, 5, 1) | led(2, 6, 2), 2, 1, 8'h44, 8'h04};
    vecs[4] = '{led(2, 5, 1) | led(2, 6, 2), 2, 2, 8'h00, 8'h00};
    vecs[5] = '{diag, 3, 0, 8'h00, 8'h00};
    vecs[6] = '{led(7, 0, 3), 7, 2, 8'h81, 8'h80};
    vecs[7] = '{led(1, 0, 2) | led(1, 7, 1), 1, 1, 8'h03, 8'h02};

    // Reset state.
    rst_n = 0; tick();
    check("rst_oe", pin_oe, 8'h00);
    check("rst_out", pin_out, 8'h00);
    check("rst_row", row_idx, 3'd0);
    check("rst_pend", load_pending, 1'b0);
    check("rst_cnt", frame_count, 8'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Diagonal-only frame: never driven, frame_done every FRAME_P clocks.
    start_with(diag);
    oe_acc = '0;
    for (int i = 0; i < FRAME_P - 1; i++) begin tick(); oe_acc |= pin_oe; end
    check("diag_done_pre", frame_done, 1'b0);
    tick();
    check("diag_done1", frame_done, 1'b1);
    check("diag_cnt1", frame_count, 8'd1);
    tick();
    check("diag_done_post", frame_done, 1'b0);
    for (int i = 0; i < FRAME_P - 1; i++) begin tick(); oe_acc |= pin_oe; end
    check("diag_done2", frame_done, 1'b1);
    check("diag_cnt2", frame_count, 8'd2);
    check("diag_oe_never", oe_acc, 8'h00);

    // Mid-frame load A, then load B on the boundary edge.
    start_with(led(0, 1, 3));
    tick();
    check("p0_oe", pin_oe, 8'h03);
    repeat (28) tick();
    fb_in = led(0, 2, 3); load = 1; tick(); load = 0;
    check("a_pend", load_pending, 1'b1);
    repeat (FRAME_P - 1 - 30) tick();
    check("a_pend_hold", load_pending, 1'b1);
    fb_in = led(0, 3, 3); load = 1; tick(); load = 0;
    check("bnd_done", frame_done, 1'b1);
    check("b_pend", load_pending, 1'b1);
    tick();
    check("a_shown_oe", pin_oe, 8'h05);
    repeat (FRAME_P) tick();
    check("b_shown_oe", pin_oe, 8'h09);
    check("b_pend_clr", load_pending, 1'b0);
    check("ab_cnt", frame_count, 8'd2);

    // Disable during row 4 DRIVE, re-enable, then reset mid-frame.
    repeat (4 * ROW_P + 2) tick();
    check("r4_row", row_idx, 3'd4);
    en = 0; tick();
    check("off_oe", pin_oe, 8'h00);
    check("off_row", row_idx, 3'd0);
    repeat (5) tick();
    check("off_cnt", frame_count, 8'd2);
    en = 1; tick();
    check("reen_row", row_idx, 3'd0);
    check("reen_done", frame_done, 1'b0);
    check("reen_oe", pin_oe, 8'h00);
    repeat (20) tick();
    rst_n = 0; tick();
    check("mrst_oe", pin_oe, 8'h00);
    check("mrst_out", pin_out, 8'h00);
    check("mrst_cnt", frame_count, 8'd0);
    rst_n = 1;

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      fb_in = {$urandom, $urandom, $urandom, $urandom};
      load  = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 299) != 0);
      rst_n = ($urandom_range(0, 1999) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
